// File: rtl/data_bus_controller_if.sv
// Bundles the MEM-stage request/response signals and the data-SRAM port of data_bus_controller.
// mem_ack exists only when DATA_BUS_ACK_EN is defined.
interface data_bus_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  ctrl_mem_read;
    logic                  ctrl_mem_write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  stall;
    logic                  bus_err;
    logic                  mem_cs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef DATA_BUS_ACK_EN
    logic                  mem_ack;
`endif

    // Controller side: responds to pipeline requests and drives the SRAM.
    modport slave (
        input  ctrl_mem_read, ctrl_mem_write, address, wdata, mem_rdata,
        output rdata, rdata_valid, stall, bus_err, mem_cs, mem_we, mem_addr, mem_wdata
`ifdef DATA_BUS_ACK_EN
        , input mem_ack
`endif
    );

    // Pipeline and memory side seen from outside the controller.
    modport master (
        output ctrl_mem_read, ctrl_mem_write, address, wdata, mem_rdata,
        input  rdata, rdata_valid, stall, bus_err, mem_cs, mem_we, mem_addr, mem_wdata
`ifdef DATA_BUS_ACK_EN
        , output mem_ack
`endif
    );
endinterface

// File: rtl/data_bus_controller.sv
// data_bus_controller: turns single-cycle MEM-stage load/store requests into a stalled multi-cycle SRAM access.
// Optional DATA_BUS_ACK_EN: access ends on mem_ack with a 255-cycle timeout instead of fixed WAIT_STATES.
module data_bus_controller #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input logic                  clk,
    input logic                  reset,
    data_bus_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvld_q, rvld_d;
    logic                  err_q, err_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  stall_c;
    logic                  finish;
    logic                  abort;
    logic                  req_rd;
    logic                  req_wr;

`ifdef DATA_BUS_ACK_EN
    // Timeout counts ACCESS cycles without ack; the 255th such cycle aborts.
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;
    logic [7:0] to_q, to_d;
`else
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    logic [3:0] wait_q, wait_d;
`endif

    assign req_rd = bus.ctrl_mem_read;
    assign req_wr = bus.ctrl_mem_write;

    always_comb begin
        finish = 1'b0;
        abort  = 1'b0;
        if (state_q == ACCESS) begin
`ifdef DATA_BUS_ACK_EN
            finish = bus.mem_ack;
            abort  = !bus.mem_ack && (to_q == TIMEOUT_LAST);
`else
            finish = (wait_q == 4'd0);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        err_d   = 1'b0;
        cs_d    = cs_q;
        we_d    = we_q;
        stall_c = 1'b0;
`ifdef DATA_BUS_ACK_EN
        to_d    = to_q;
`else
        wait_d  = wait_q;
`endif
        case (state_q)
            IDLE: begin
                stall_c = req_rd ^ req_wr;
                if (req_rd ^ req_wr) begin
                    state_d = ACCESS;
                    addr_d  = bus.address;
                    wdata_d = bus.wdata;
                    cs_d    = 1'b1;
                    we_d    = req_wr;
`ifdef DATA_BUS_ACK_EN
                    to_d    = 8'd0;
`else
                    wait_d  = WAIT_INIT;
`endif
                end else if (req_rd && req_wr) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                // Request inputs are not looked at here: a started access always completes.
                stall_c = 1'b1;
                err_d   = abort;
                if (finish || abort) begin
                    state_d = DONE;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                end
                if (finish && !we_q) begin
                    rdata_d = bus.mem_rdata;
                    rvld_d  = 1'b1;
                end
`ifdef DATA_BUS_ACK_EN
                if (!finish && !abort) to_d = to_q + 8'd1;
`else
                if (!finish) wait_d = wait_q - 4'd1;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
`ifdef DATA_BUS_ACK_EN
            to_q    <= '0;
`else
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
`ifdef DATA_BUS_ACK_EN
            to_q    <= to_d;
`else
            wait_q  <= wait_d;
`endif
        end
    end

    assign bus.stall       = reset & stall_c;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvld_q;
    assign bus.bus_err     = err_q;
    assign bus.mem_cs      = cs_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
endmodule

// File: tb/tb_data_bus_controller.sv
// Bench for data_bus_controller: two instances (WAIT_STATES 1 and 0) checked against transaction-level timing rules.
`timescale 1ns/1ps
module tb_data_bus_controller;
    localparam int DW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_bus_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    data_bus_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

    data_bus_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    data_bus_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    int checks = 0;
    int failures = 0;
    logic sel = 1'b1;
    logic [DW-1:0] last_rd [2];

    logic o_stall, o_cs, o_we, o_vld, o_err;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rdata;

    always_comb begin
        if (sel) begin
            o_stall = bus1.stall; o_cs = bus1.mem_cs; o_we = bus1.mem_we; o_vld = bus1.rdata_valid;
            o_err = bus1.bus_err; o_addr = bus1.mem_addr; o_wdata = bus1.mem_wdata; o_rdata = bus1.rdata;
        end else begin
            o_stall = bus0.stall; o_cs = bus0.mem_cs; o_we = bus0.mem_we; o_vld = bus0.rdata_valid;
            o_err = bus0.bus_err; o_addr = bus0.mem_addr; o_wdata = bus0.mem_wdata; o_rdata = bus0.rdata;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus0.ctrl_mem_read = 1'b0; bus0.ctrl_mem_write = 1'b0; bus0.address = '0; bus0.wdata = '0;
        bus1.ctrl_mem_read = 1'b0; bus1.ctrl_mem_write = 1'b0; bus1.address = '0; bus1.wdata = '0;
        if (sel) begin
            bus1.ctrl_mem_read = rd; bus1.ctrl_mem_write = wr; bus1.address = a; bus1.wdata = d;
        end else begin
            bus0.ctrl_mem_read = rd; bus0.ctrl_mem_write = wr; bus0.address = a; bus0.wdata = d;
        end
    endtask

    task automatic set_mem(input logic [DW-1:0] v);
        bus0.mem_rdata = v;
        bus1.mem_rdata = v;
    endtask

`ifdef DATA_BUS_ACK_EN
    task automatic set_ack(input logic v);
        bus0.mem_ack = v;
        bus1.mem_ack = v;
    endtask
`endif

    // One access on the selected instance; expectations come from the latency rules for wait count W.
    task automatic do_access(input logic s, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] mv);
        int W;
        int stall_cnt;
        logic e_cs, e_stall, e_vld;
        logic [DW-1:0] e_rd;
        W = s ? 1 : 0;
        sel = s;
        stall_cnt = 0;
        for (int c = 0; c <= W + 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(!w, w, a, d);
            else drive(1'b0, 1'b0, 16'($urandom), 8'($urandom));
            set_mem((c == W + 1) ? mv : ~mv);
`ifdef DATA_BUS_ACK_EN
            set_ack(c == W + 1);
`endif
            @(negedge clk);
            e_cs = (c >= 1) && (c <= W + 1);
            e_stall = (c <= W + 1);
            e_vld = (c == W + 2) && !w;
            e_rd = (c == W + 2 && !w) ? mv : last_rd[s];
            checks++; if (o_stall !== e_stall) begin failures++; $display("FAIL acc_stall c=%0d got=%b exp=%b", c, o_stall, e_stall); end
            checks++; if (o_cs !== e_cs) begin failures++; $display("FAIL acc_cs c=%0d got=%b exp=%b", c, o_cs, e_cs); end
            checks++; if (o_we !== (e_cs && w)) begin failures++; $display("FAIL acc_we c=%0d got=%b exp=%b", c, o_we, e_cs && w); end
            checks++; if (o_vld !== e_vld) begin failures++; $display("FAIL acc_rvalid c=%0d got=%b exp=%b", c, o_vld, e_vld); end
            checks++; if (o_rdata !== e_rd) begin failures++; $display("FAIL acc_rdata c=%0d got=%h exp=%h", c, o_rdata, e_rd); end
            checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL acc_buserr c=%0d got=%b exp=0", c, o_err); end
            if (e_cs) begin
                checks++; if (o_addr !== a) begin failures++; $display("FAIL acc_addr c=%0d got=%h exp=%h", c, o_addr, a); end
                if (w) begin
                    checks++; if (o_wdata !== d) begin failures++; $display("FAIL acc_wdata c=%0d got=%h exp=%h", c, o_wdata, d); end
                end
            end
            if (o_stall) stall_cnt++;
        end
        if (!w) last_rd[s] = mv;
        checks++; if (stall_cnt != W + 2) begin failures++; $display("FAIL acc_stall_len got=%0d exp=%0d", stall_cnt, W + 2); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, '0, '0);
            @(negedge clk);
            checks++; if (o_cs !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL idle cs=%b stall=%b exp=0", o_cs, o_stall); end
        end
    endtask

    task automatic test_reset();
        sel = 1'b1;
        drive(1'b1, 1'b0, 16'h1234, 8'h56);
        set_mem('0);
`ifdef DATA_BUS_ACK_EN
        set_ack(1'b0);
`endif
        repeat (2) @(negedge clk);
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", o_stall); end
        checks++; if ({bus1.mem_cs, bus1.mem_we, bus1.rdata_valid, bus1.bus_err, bus1.rdata, bus1.mem_addr, bus1.mem_wdata} !== '0)
            begin failures++; $display("FAIL rst_outputs1 got=%h exp=0", {bus1.rdata, bus1.mem_addr, bus1.mem_wdata}); end
        checks++; if ({bus0.mem_cs, bus0.mem_we, bus0.rdata_valid, bus0.bus_err, bus0.rdata, bus0.mem_addr, bus0.mem_wdata, bus0.stall} !== '0)
            begin failures++; $display("FAIL rst_outputs0 got=%h exp=0", {bus0.rdata, bus0.mem_addr, bus0.mem_wdata}); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic test_read_w1();
        do_access(1'b1, 1'b0, 16'h0100, 8'h00, 8'hA5);
        idle(2);
    endtask

    task automatic test_write_w0();
        do_access(1'b0, 1'b1, 16'h0060, 8'h3C, 8'h77);
        idle(2);
    endtask

    task automatic test_bus_err(input logic s);
        sel = s;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 16'h0200, 8'h99);
        @(negedge clk);
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL err_stall got=%b exp=0", o_stall); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", o_err); end
        checks++; if (o_cs !== 1'b0) begin failures++; $display("FAIL err_cs got=%b exp=0", o_cs); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_err !== 1'b0 || o_cs !== 1'b0) begin failures++; $display("FAIL err_single err=%b cs=%b exp=0", o_err, o_cs); end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 16'h0010, 8'h00, 8'h11);
        do_access(1'b1, 1'b0, 16'h0011, 8'h00, 8'h22);
        idle(2);
    endtask

    task automatic test_reset_mid_access();
        do_access(1'b1, 1'b0, 16'h0100, 8'h00, 8'hA5);
        sel = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'h0300, 8'h00);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (o_cs !== 1'b1) begin failures++; $display("FAIL midrst_cs_before got=%b exp=1", o_cs); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", o_stall); end
        checks++; if (o_cs !== 1'b0) begin failures++; $display("FAIL midrst_cs got=%b exp=0", o_cs); end
        checks++; if (o_rdata !== '0) begin failures++; $display("FAIL midrst_rdata got=%h exp=00", o_rdata); end
        checks++; if ({o_we, o_vld, o_err, o_addr, o_wdata} !== '0) begin failures++; $display("FAIL midrst_outs got=%h exp=0", {o_addr, o_wdata}); end
        @(posedge clk); #1;
        reset = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        idle(2);
    endtask

    task automatic test_random();
        logic s, w;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            w = 1'($urandom);
            do_access(s, w, 16'($urandom), 8'($urandom), 8'($urandom));
            idle($urandom_range(0, 2));
        end
    endtask

`ifdef DATA_BUS_ACK_EN
    task automatic test_ack();
        int cs_cnt;
        sel = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'h0400, 8'h00);
        set_mem(8'h5A);
        set_ack(1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, '0, '0);
            set_ack(c == 6);
            @(negedge clk);
            checks++; if (o_cs !== 1'b1) begin failures++; $display("FAIL ack_cs c=%0d got=%b exp=1", c, o_cs); end
        end
        @(posedge clk); #1;
        set_ack(1'b0);
        @(negedge clk);
        checks++; if (o_vld !== 1'b1 || o_rdata !== 8'h5A) begin failures++; $display("FAIL ack_done vld=%b rdata=%h exp=1/5a", o_vld, o_rdata); end
        last_rd[1] = 8'h5A;
        idle(1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'h0500, 8'h00);
        set_mem(8'hEE);
        cs_cnt = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (o_cs) cs_cnt++;
            else break;
        end
        checks++; if (cs_cnt != 255) begin failures++; $display("FAIL ack_timeout_len got=%0d exp=255", cs_cnt); end
        checks++; if (o_err !== 1'b1 || o_vld !== 1'b0) begin failures++; $display("FAIL ack_timeout_err err=%b vld=%b exp=1/0", o_err, o_vld); end
        checks++; if (o_rdata !== 8'h5A) begin failures++; $display("FAIL ack_timeout_rdata got=%h exp=5a", o_rdata); end
        idle(2);
    endtask
`endif

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        test_reset();
        test_read_w1();
        test_write_w0();
        test_bus_err(1'b1);
        test_bus_err(1'b0);
        test_back_to_back();
        test_reset_mid_access();
        test_random();
`ifdef DATA_BUS_ACK_EN
        test_ack();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
